// File: rtl/imem_loader.sv
// imem_loader: receives a framed byte stream and writes 32-bit instruction
// words into the program BRAM write port. The CPU is held in reset until a
// frame passes its checksum.
//
// Frame: N (16-bit, LSB first) | 4N data bytes (little-endian words) | XOR byte
//
// Ports:
//   sysclk      system clock, rising edge
//   rst         synchronous active-high reset
//   load_start  one-cycle request to begin a frame (IDLE/DONE/ERR only)
//   in_valid    in_data holds a byte
//   in_data     stream byte
//   in_ready    loader accepts a byte this cycle
//   wr_addr     BRAM write byte address (word aligned)
//   ram_in      BRAM write data
//   byte_w_en   BRAM byte write enables
//   cpu_rst     CPU reset hold, active high
//   busy        frame in progress
//   done        sticky: last frame loaded successfully
//   error       sticky: last frame failed
module imem_loader #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned MAX_WORDS  = 1024
) (
  input  logic                  sysclk,
  input  logic                  rst,
  input  logic                  load_start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [31:0]           ram_in,
  output logic [3:0]            byte_w_en,
  output logic                  cpu_rst,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {
    IDLE, HDR0, HDR1, DATA, WRITE, CHK, DONE, ERR
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  n_lo;
  logic [15:0] n_words;
  logic [15:0] word_idx;
  logic [1:0]  byte_idx;
  logic [7:0]  acc;
  logic [31:0] word_asm;

  logic        take;
  logic [15:0] n_hdr;
  logic [31:0] word_nxt;

  always_comb begin
    take     = in_valid && in_ready;
    n_hdr    = {in_data, n_lo};
    // Bytes shift in from the top so the first byte ends up in [7:0].
    word_nxt = {in_data, word_asm[31:8]};
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE, ERR: if (load_start) state_nxt = HDR0;
      HDR0:  if (take) state_nxt = HDR1;
      HDR1: begin
        if (take) begin
          if (32'(n_hdr) > MAX_WORDS) state_nxt = ERR;
          else if (n_hdr == 16'd0)    state_nxt = CHK;
          else                        state_nxt = DATA;
        end
      end
      DATA:  if (take && byte_idx == 2'd3) state_nxt = WRITE;
      WRITE: state_nxt = (word_idx + 16'd1 == n_words) ? CHK : DATA;
      CHK:   if (take) state_nxt = (in_data == acc) ? DONE : ERR;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the
  // state they describe, starting in the cycle the state is entered.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      wr_addr   <= '0;
      ram_in    <= '0;
      byte_w_en <= '0;
      cpu_rst   <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      n_lo      <= '0;
      n_words   <= '0;
      word_idx  <= '0;
      byte_idx  <= '0;
      acc       <= '0;
      word_asm  <= '0;
    end else begin
      state     <= state_nxt;
      in_ready  <= state_nxt inside {HDR0, HDR1, DATA, CHK};
      busy      <= state_nxt inside {HDR0, HDR1, DATA, WRITE, CHK};
      byte_w_en <= (state_nxt == WRITE) ? 4'hF : 4'h0;
      done      <= (state_nxt == DONE);
      error     <= (state_nxt == ERR);
      cpu_rst   <= (state_nxt != DONE);

      case (state)
        IDLE, DONE, ERR: begin
          if (load_start) begin
            word_idx <= '0;
            byte_idx <= '0;
            acc      <= '0;
          end
        end
        HDR0: if (take) n_lo <= in_data;
        HDR1: if (take) n_words <= n_hdr;
        DATA: begin
          if (take) begin
            word_asm <= word_nxt;
            acc      <= acc ^ in_data;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              ram_in  <= word_nxt;
              wr_addr <= ADDR_WIDTH'({word_idx, 2'b00});
            end
          end
        end
        WRITE: word_idx <= word_idx + 16'd1;
        default: ;
      endcase
    end
  end

endmodule
